// File: rtl/seg_quire_acc_if.sv
// Term-input / result-output bundle for the segmented quire accumulator.
// The master drives terms and consumes results; the slave is the accumulator.
interface seg_quire_acc_if #(
    parameter int MW    = 8,
    parameter int SEGW  = 24,
    parameter int NSEG  = 4,
    parameter int HEADW = 6,
    parameter int MAXK  = 16
);
    localparam int BW   = NSEG * SEGW;
    localparam int TW   = HEADW + BW;
    localparam int POSW = $clog2(BW);
    localparam int LW   = $clog2(MAXK + 1);

    logic            start;
    logic [LW-1:0]   cfg_len;
    logic            in_vld;
    logic            in_rdy;
    logic            in_sign;
    logic [MW-1:0]   in_mts;
    logic [POSW-1:0] in_pos;
    logic            out_vld;
    logic            out_rdy;
    logic [TW-1:0]   out_acc;
    logic            out_ovf;
    logic            busy;

    modport master (
        output start, cfg_len, in_vld, in_sign, in_mts, in_pos, out_rdy,
        input  in_rdy, out_vld, out_acc, out_ovf, busy
    );

    modport slave (
        input  start, cfg_len, in_vld, in_sign, in_mts, in_pos, out_rdy,
        output in_rdy, out_vld, out_acc, out_ovf, busy
    );
endinterface

// File: rtl/seg_quire_acc.sv
// Segmented carry-save quire accumulator for the posit MAC datapath.
// Optional macro QACC_OVF_EN widens the head by 2 bits and reports signed overflow on out_ovf.
module seg_quire_acc #(
    parameter int MW    = 8,
    parameter int SEGW  = 24,
    parameter int NSEG  = 4,
    parameter int HEADW = 6,
    parameter int MAXK  = 16
) (
    input  logic           clk_i,
    input  logic           rstn,
    seg_quire_acc_if.slave bus
);
    localparam int BW  = NSEG * SEGW;
    localparam int TW  = HEADW + BW;
    localparam int LW  = $clog2(MAXK + 1);
    localparam int FCW = $clog2(NSEG + 1);
`ifdef QACC_OVF_EN
    localparam int HW  = HEADW + 2;
`else
    localparam int HW  = HEADW;
`endif

    typedef enum logic [1:0] {IDLE, ACC, FLUSH, DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [LW-1:0]    r_len;
    logic [LW-1:0]    r_cnt;
    logic [FCW-1:0]   r_fcnt;
    logic [SEGW+1:0]  r_seg [NSEG];
    logic [HW-1:0]    r_head;
    logic [TW-1:0]    r_acc;

    logic             w_accept;
    logic             w_lastTerm;
    logic             w_flushDone;
    logic [TW-1:0]    w_shift;
    logic [TW-1:0]    w_opnd;
    logic [SEGW-1:0]  w_slice   [NSEG];
    logic [1:0]       w_cin     [NSEG];
    logic [SEGW+1:0]  w_segNext [NSEG];
    logic [BW-1:0]    w_body;
    logic [HW-1:0]    w_hslice;
    logic [HW-1:0]    w_headNext;

    assign w_accept    = (r_state == ACC) && bus.in_vld;
    assign w_lastTerm  = w_accept && ((r_cnt + LW'(1)) == r_len);
    assign w_flushDone = (r_state == FLUSH) && (r_fcnt == FCW'(NSEG));

    assign w_shift = {{(TW-MW){1'b0}}, bus.in_mts} << bus.in_pos;
    assign w_opnd  = bus.in_sign ? -w_shift : w_shift;

    // Each segment adds its own payload, its slice and the guard bits of the segment below.
    for (genvar gi = 0; gi < NSEG; gi++) begin : g_seg
        if (gi == 0) begin : g_lo
            assign w_cin[gi] = 2'b00;
        end else begin : g_hi
            assign w_cin[gi] = r_seg[gi-1][SEGW+1:SEGW];
        end
        assign w_slice[gi]   = w_accept ? w_opnd[gi*SEGW +: SEGW] : '0;
        assign w_segNext[gi] = {2'b00, r_seg[gi][SEGW-1:0]} + {2'b00, w_slice[gi]}
                             + {{SEGW{1'b0}}, w_cin[gi]};
        assign w_body[gi*SEGW +: SEGW] = r_seg[gi][SEGW-1:0];
    end

`ifdef QACC_OVF_EN
    assign w_hslice = w_accept ? {{2{w_opnd[TW-1]}}, w_opnd[TW-1 -: HEADW]} : '0;
`else
    assign w_hslice = w_accept ? w_opnd[TW-1 -: HEADW] : '0;
`endif
    assign w_headNext = r_head + w_hslice + {{(HW-2){1'b0}}, r_seg[NSEG-1][SEGW+1:SEGW]};

    always_ff @(posedge clk_i or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_next = (bus.cfg_len == '0) ? FLUSH : ACC;
            ACC:     if (w_lastTerm) w_next = FLUSH;
            FLUSH:   if (w_flushDone) w_next = DONE;
            DONE:    if (bus.out_rdy) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // FLUSH keeps propagating guard bits; the extra cycle after NSEG updates captures the result.
    always_ff @(posedge clk_i or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NSEG; i++) r_seg[i] <= '0;
            r_head <= '0;
            r_len  <= '0;
            r_cnt  <= '0;
            r_fcnt <= '0;
            r_acc  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    for (int i = 0; i < NSEG; i++) r_seg[i] <= '0;
                    r_head <= '0;
                    r_fcnt <= '0;
                    if (bus.start) begin
                        r_len <= bus.cfg_len;
                        r_cnt <= '0;
                    end
                end
                ACC: begin
                    if (w_accept) begin
                        for (int i = 0; i < NSEG; i++) r_seg[i] <= w_segNext[i];
                        r_head <= w_headNext;
                        r_cnt  <= r_cnt + LW'(1);
                    end
                end
                FLUSH: begin
                    for (int i = 0; i < NSEG; i++) r_seg[i] <= w_segNext[i];
                    r_head <= w_headNext;
                    if (w_flushDone) begin
                        r_acc <= {r_head[HEADW-1:0], w_body};
                    end else begin
                        r_fcnt <= r_fcnt + FCW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef QACC_OVF_EN
    logic r_ovf;

    always_ff @(posedge clk_i or negedge rstn) begin
        if (!rstn) begin
            r_ovf <= 1'b0;
        end else if (r_state == IDLE) begin
            r_ovf <= 1'b0;
        end else if (w_flushDone) begin
            r_ovf <= !((r_head[HEADW+1] == r_head[HEADW]) && (r_head[HEADW] == r_head[HEADW-1]));
        end
    end

    assign bus.out_ovf = r_ovf;
`else
    assign bus.out_ovf = 1'b0;
`endif

    assign bus.in_rdy  = (r_state == ACC);
    assign bus.out_vld = (r_state == DONE);
    assign bus.busy    = (r_state != IDLE);
    assign bus.out_acc = r_acc;
endmodule

// File: tb/tb_seg_quire_acc.sv
// Scoreboard bench for seg_quire_acc: expected sums are queued as terms are driven
// and popped when the accumulator presents its result.
module tb_seg_quire_acc;
    localparam int MW    = 8;
    localparam int SEGW  = 24;
    localparam int NSEG  = 4;
    localparam int HEADW = 6;
    localparam int MAXK  = 16;
    localparam int TW    = HEADW + NSEG * SEGW;
    localparam int POSW  = $clog2(NSEG * SEGW);
    localparam int LW    = $clog2(MAXK + 1);

    typedef struct {
        logic [TW-1:0] acc;
        logic          ovf;
    } result_t;

    logic clk_i = 1'b0;
    logic rstn  = 1'b0;
    always #5 clk_i = ~clk_i;

    seg_quire_acc_if #(.MW(MW), .SEGW(SEGW), .NSEG(NSEG), .HEADW(HEADW), .MAXK(MAXK)) bus ();

    seg_quire_acc #(.MW(MW), .SEGW(SEGW), .NSEG(NSEG), .HEADW(HEADW), .MAXK(MAXK)) dut (
        .clk_i (clk_i),
        .rstn  (rstn),
        .bus   (bus)
    );

    result_t            expQ[$];
    int                 total = 0;
    int                 bad = 0;
    int                 cycle = 0;
    int                 acceptCycle = 0;
    logic signed [127:0] modelSum;

    always @(posedge clk_i) cycle <= cycle + 1;

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Signed value of one term as the TW-bit operand the quire sees.
    function automatic logic signed [127:0] termValue(input logic sgn, input logic [MW-1:0] mts, input int pos);
        logic [127:0]  m;
        logic [TW-1:0] t;
        m = {{(128-MW){1'b0}}, mts} << pos;
        if (sgn) m = -m;
        t = m[TW-1:0];
        return {{(128-TW){t[TW-1]}}, t};
    endfunction

    task automatic startJob(input int len);
        bus.start   = 1'b1;
        bus.cfg_len = LW'(len);
        modelSum    = '0;
        @(negedge clk_i);
        bus.start   = 1'b0;
        acceptCycle = cycle;
    endtask

    task automatic applyStimulus(input logic sgn, input logic [MW-1:0] mts, input int pos);
        bit ok;
        ok          = 1'b0;
        bus.in_vld  = 1'b1;
        bus.in_sign = sgn;
        bus.in_mts  = mts;
        bus.in_pos  = POSW'(pos);
        for (int k = 0; k < 50; k++) begin
            if (bus.in_rdy === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk_i);
        end
        if (!ok) begin
            checkOutput("accept_timeout", 0, 1);
        end else begin
            @(negedge clk_i);
            acceptCycle = cycle;
            modelSum    = modelSum + termValue(sgn, mts, pos);
        end
        bus.in_vld = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        bus.in_vld = 1'b0;
        for (int k = 0; k < n; k++) begin
            bus.in_sign = 1'($urandom);
            bus.in_mts  = MW'($urandom);
            bus.in_pos  = POSW'($urandom);
            @(negedge clk_i);
        end
    endtask

    task automatic pushExpected();
        result_t r;
        r.acc = modelSum[TW-1:0];
`ifdef QACC_OVF_EN
        r.ovf = !((&modelSum[127:TW-1]) || !(|modelSum[127:TW-1]));
`else
        r.ovf = 1'b0;
`endif
        expQ.push_back(r);
    endtask

    task automatic waitResult(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (bus.out_vld === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk_i);
        end
        if (!ok) checkOutput("out_vld_timeout", 0, 1);
    endtask

    task automatic collectResult(input string tag, input bit checkLat);
        bit      ok;
        result_t r;
        waitResult(ok);
        if (ok) begin
            if (checkLat) checkOutput({tag, ".latency"}, 128'(cycle - acceptCycle), 128'(NSEG + 1));
            if (expQ.size() == 0) begin
                checkOutput({tag, ".queue_empty"}, 0, 1);
            end else begin
                r = expQ.pop_front();
                checkOutput({tag, ".acc"}, 128'(bus.out_acc), 128'(r.acc));
                checkOutput({tag, ".ovf"}, 128'(bus.out_ovf), 128'(r.ovf));
            end
            bus.out_rdy = 1'b1;
            @(negedge clk_i);
            bus.out_rdy = 1'b0;
            checkOutput({tag, ".busy_after"}, 128'(bus.busy), 0);
            checkOutput({tag, ".vld_after"}, 128'(bus.out_vld), 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [TW-1:0] held;
        bus.start   = 1'b0;
        bus.cfg_len = '0;
        bus.in_vld  = 1'b0;
        bus.in_sign = 1'b0;
        bus.in_mts  = '0;
        bus.in_pos  = '0;
        bus.out_rdy = 1'b0;
        modelSum    = '0;
        repeat (2) @(negedge clk_i);
        checkOutput("rst.in_rdy", 128'(bus.in_rdy), 0);
        checkOutput("rst.out_vld", 128'(bus.out_vld), 0);
        checkOutput("rst.out_acc", 128'(bus.out_acc), 0);
        checkOutput("rst.out_ovf", 128'(bus.out_ovf), 0);
        checkOutput("rst.busy", 128'(bus.busy), 0);
        rstn = 1'b1;
        @(negedge clk_i);

        // Small signed sum, back-to-back terms
        startJob(3);
        applyStimulus(1'b0, 8'd5, 0);
        applyStimulus(1'b0, 8'd3, 0);
        applyStimulus(1'b1, 8'd2, 0);
        pushExpected();
        collectResult("t1", 1'b1);

        // Terms straddling the seg0/seg1 boundary, back-to-back then with gaps
        startJob(2);
        applyStimulus(1'b0, 8'hFF, 20);
        applyStimulus(1'b0, 8'hFF, 20);
        pushExpected();
        collectResult("t2a", 1'b1);
        startJob(2);
        applyStimulus(1'b0, 8'hFF, 20);
        idleCycles(3);
        applyStimulus(1'b0, 8'hFF, 20);
        pushExpected();
        collectResult("t2b", 1'b1);

        // Negative terms sign-extending through the head
        startJob(1);
        applyStimulus(1'b1, 8'd1, 0);
        pushExpected();
        collectResult("t3a", 1'b1);
        startJob(1);
        applyStimulus(1'b1, 8'h80, 90);
        pushExpected();
        collectResult("t3b", 1'b1);

        // Backpressure in DONE with start and in_vld noise
        startJob(1);
        applyStimulus(1'b0, 8'd9, 3);
        pushExpected();
        begin
            bit ok;
            waitResult(ok);
        end
        for (int k = 0; k < 5; k++) begin
            bus.start   = 1'b1;
            bus.cfg_len = LW'(2);
            bus.in_vld  = 1'b1;
            bus.in_mts  = 8'h33;
            @(negedge clk_i);
            checkOutput("t4.hold_vld", 128'(bus.out_vld), 1);
            checkOutput("t4.hold_acc", 128'(bus.out_acc), 128'(expQ[0].acc));
            checkOutput("t4.hold_rdy", 128'(bus.in_rdy), 0);
            checkOutput("t4.hold_busy", 128'(bus.busy), 1);
        end
        bus.start  = 1'b0;
        bus.in_vld = 1'b0;
        held = expQ[0].acc;
        collectResult("t4", 1'b0);
        checkOutput("t4.acc_held", 128'(bus.out_acc), 128'(held));

        // Zero-length job
        startJob(0);
        pushExpected();
        collectResult("t5a", 1'b1);

        // Reset mid-accumulation aborts without output
        startJob(4);
        applyStimulus(1'b0, 8'd5, 0);
        rstn = 1'b0;
        #1;
        checkOutput("t5b.in_rdy", 128'(bus.in_rdy), 0);
        checkOutput("t5b.out_vld", 128'(bus.out_vld), 0);
        checkOutput("t5b.out_acc", 128'(bus.out_acc), 0);
        checkOutput("t5b.out_ovf", 128'(bus.out_ovf), 0);
        checkOutput("t5b.busy", 128'(bus.busy), 0);
        @(negedge clk_i);
        rstn = 1'b1;
        @(negedge clk_i);
        startJob(1);
        applyStimulus(1'b0, 8'd7, 0);
        pushExpected();
        collectResult("t5c", 1'b1);

        // Sum of 2^101 lands outside the signed TW range
        startJob(2);
        applyStimulus(1'b0, 8'h20, 95);
        applyStimulus(1'b0, 8'h20, 95);
        pushExpected();
        collectResult("t6", 1'b1);

        // Random mixed-sign jobs
        for (int j = 0; j < 4; j++) begin
            int n;
            n = int'($urandom_range(1, MAXK));
            startJob(n);
            for (int k = 0; k < n; k++) begin
                applyStimulus(1'($urandom), MW'($urandom), int'($urandom_range(0, 88)));
                if ($urandom_range(0, 3) == 0) idleCycles(int'($urandom_range(1, 2)));
            end
            pushExpected();
            collectResult("rand", 1'b1);
        end

        if (expQ.size() != 0) checkOutput("queue_leftover", 128'(expQ.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seg_quire_acc.md
Name: seg_quire_acc

Overview:
Parametrised segmented fixed-point accumulator (quire) for the posit MAC datapath. It sums a runtime-programmed number of signed, pre-scaled mantissa products into a wide register split into NSEG body segments plus a signed head segment. Carries are carry-saved per cycle and resolved in a final flush phase. The finished sum is presented on a valid/ready output toward the posit normaliser.

Parameters:
MW, 8, magnitude width of the incoming product mantissa
SEGW, 24, payload bits per body segment (each register holds SEGW+2 bits, with 2 carry guard bits)
NSEG, 4, number of body segments (>=2)
HEADW, 6, signed head segment width
MAXK, 16, maximum terms per accumulation
Derived: BW=NSEG*SEGW; TW=HEADW+BW; POSW=$clog2(BW); LW=$clog2(MAXK+1)

Ports:
clk_i  in  1  clock
rstn  in  1  asynchronous active-low reset
start  in  1  begin a new accumulation (honoured in IDLE only)
cfg_len  in  LW  number of terms, sampled with start
in_vld  in  1  term valid
in_rdy  out  1  term accepted when in_vld&in_rdy
in_sign  in  1  term sign (1 = negative)
in_mts  in  MW  term magnitude
in_pos  in  POSW  bit position of in_mts LSB within the body
out_vld  out  1  result valid
out_rdy  in  1  result consumed when out_vld&out_rdy
out_acc  out  TW  two's-complement sum {head, seg[NSEG-1..0] payloads}
out_ovf  out  1  sum exceeded TW signed range (see Optional Feature)
busy  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock clk_i; reset rstn is asynchronous and active-low.
- Reset: state=IDLE; all segments, head, counters = 0; in_rdy=0, out_vld=0, out_acc=0, out_ovf=0, busy=0. Reset in any state aborts the accumulation with no output.
- FSM states: IDLE, ACC, FLUSH, DONE.
- IDLE: clear all segments and head. On start: latch cfg_len, count=0. Go to ACC, or to FLUSH if cfg_len=0 (the result is then 0).
- ACC: in_rdy=1.
  - Each accepted term: operand = (in_sign ? -in_mts : in_mts) << in_pos, formed in TW-bit two's complement. Bits above TW are discarded (modulo 2^TW).
  - Slice i = operand[i*SEGW +: SEGW] (unsigned); head slice = top HEADW bits.
  - Same edge, for every segment: seg[i] <= seg[i][SEGW-1:0] + slice_i + seg[i-1][SEGW+1:SEGW], with seg[-1] guard = 0.
  - head <= head + head_slice + seg[NSEG-1][SEGW+1:SEGW], modulo head width.
  - count++. On the cfg_len-th accept go to FLUSH.
  - Cycles with in_vld=0 change nothing.
- FLUSH: in_rdy=0. Apply the same update with all slices 0 for exactly NSEG cycles, which guarantees every guard bit reads 0. Then go to DONE.
- Latency: last term accepted at edge t; out_vld rises at edge t+NSEG+1.
- DONE: out_vld=1; out_acc and out_ovf are stable while out_rdy=0. On out_vld&out_rdy go to IDLE; out_vld falls next cycle.
- start outside IDLE is ignored. in_vld outside ACC is ignored.
- out_acc holds its last value after DONE until the next DONE.

Optional Feature:
QACC_OVF_EN
- Defined: head register is HEADW+2 bits wide.
  - On DONE entry, out_ovf = NOT(head[HEADW+1], head[HEADW], head[HEADW-1] all equal).
  - out_acc uses head[HEADW-1:0].
  - out_ovf clears in IDLE.
- Undefined: head register is HEADW bits and out_ovf is tied 0.

Test Plan:
1. Defaults, cfg_len=3; terms +5@0, +3@0, -2@0 back-to-back -> out_acc=6, out_vld exactly 5 cycles after the 3rd accept, out_ovf=0.
2. cfg_len=2; two terms +0xFF@20 (crossing the seg0/seg1 boundary) -> out_acc=0x1FE00000. Insert 3 idle in_vld=0 cycles between the terms -> identical result.
3. cfg_len=1; term -1@0 -> out_acc all ones (TW bits); cfg_len=1, term -0x80@90 -> out_acc = -(0x80<<90) mod 2^102.
4. Backpressure: hold out_rdy=0 for 5 cycles in DONE, pulse start, drive in_vld -> out_vld/out_acc stable, in_rdy=0, busy=1. Raise out_rdy -> IDLE next cycle, busy=0.
5. cfg_len=0 -> DONE after NSEG cycles with out_acc=0. Separately, assert rstn=0 mid-ACC after 1 of 4 terms -> all outputs 0 and IDLE; a subsequent cfg_len=1, +7@0 run -> out_acc=7.
6. With QACC_OVF_EN, cfg_len=2; terms +0x20@95 twice (sum 2^101) -> out_ovf=1. Without the macro -> out_ovf=0, out_acc=1<<101.
